lcd_writer: RTL and testbench

LCD_WRITER -- requirements
Module: lcd_writer

---
 rtl/lcd_writer.sv | 198 +++++++++++++++++++
 tb/tb_lcd_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_writer.sv
// HD44780 8-bit writer: power-up wait, four-command init, then repaints a two-line
// scoreboard frame forever from a per-frame snapshot of the character inputs.
module lcd_writer #(
    parameter int unsigned T_PWR = 750000,
    parameter int unsigned T_EN  = 12,
    parameter int unsigned T_CMD = 2500,
    parameter int unsigned T_CLR = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_0_H,
    input  logic [7:0] ascii_1_H,
    input  logic [7:0] ascii_2_H,
    input  logic [7:0] ascii_0_G,
    input  logic [7:0] ascii_1_G,
    input  logic [7:0] ascii_2_G,
    input  logic [7:0] ascii_0_min,
    input  logic [7:0] ascii_1_min,
    input  logic [7:0] ascii_0_sec,
    input  logic [7:0] ascii_1_sec,
    input  logic [7:0] ascii_0_period,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       frame_done
);

    localparam int unsigned CntW = ($clog2(T_PWR + 1) > 20) ? $clog2(T_PWR + 1) : 20;

    localparam logic [4:0] LastInitIdx  = 5'd3;
    localparam logic [4:0] LastFrameIdx = 5'd21;

    typedef enum logic [1:0] {
        StPwrWait,
        StSetup,
        StEnHi,
        StWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [4:0]      idx_q, idx_d;
    logic            init_q, init_d;
    logic            frame_done_q, frame_done_d;
    logic [10:0][7:0] snap_q, snap_d;

    logic       step_rs;
    logic [7:0] step_byte;
    logic       cnt_last;
    logic       clr_step;

    assign cnt_last = (cnt_q == CntW'(1));
    // Only the final init command (clear display) needs the long settle time.
    assign clr_step = init_q && (idx_q == LastInitIdx);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StPwrWait;
            cnt_q        <= CntW'(T_PWR);
            idx_q        <= 5'd0;
            init_q       <= 1'b1;
            frame_done_q <= 1'b0;
            snap_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            init_q       <= init_d;
            frame_done_q <= frame_done_d;
            snap_q       <= snap_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        init_d       = init_q;
        frame_done_d = 1'b0;
        snap_d       = snap_q;

        unique case (state_q)
            StPwrWait: begin
                if (cnt_last) begin
                    state_d = StSetup;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StSetup: begin
                state_d = StEnHi;
                cnt_d   = CntW'(T_EN);
                if (!init_q && (idx_q == 5'd0)) begin
                    snap_d = {ascii_2_H, ascii_1_H, ascii_0_H,
                              ascii_2_G, ascii_1_G, ascii_0_G,
                              ascii_1_min, ascii_0_min,
                              ascii_1_sec, ascii_0_sec,
                              ascii_0_period};
                end
            end
            StEnHi: begin
                if (cnt_last) begin
                    state_d = StWait;
                    cnt_d   = clr_step ? CntW'(T_CLR) : CntW'(T_CMD);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWait: begin
                if (cnt_last) begin
                    state_d = StSetup;
                    if (init_q) begin
                        if (idx_q == LastInitIdx) begin
                            init_d = 1'b0;
                            idx_d  = 5'd0;
                        end else begin
                            idx_d = idx_q + 5'd1;
                        end
                    end else if (idx_q == LastFrameIdx) begin
                        idx_d        = 5'd0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StPwrWait;
        endcase
    end

    // Byte and register select for the current step; snap_q index 10 is ascii_2_H.
    always_comb begin
        step_rs   = 1'b1;
        step_byte = 8'h00;
        if (init_q) begin
            step_rs = 1'b0;
            unique case (idx_q[1:0])
                2'd0:    step_byte = 8'h38;
                2'd1:    step_byte = 8'h0C;
                2'd2:    step_byte = 8'h06;
                default: step_byte = 8'h01;
            endcase
        end else begin
            case (idx_q)
                5'd0: begin
                    step_rs   = 1'b0;
                    step_byte = 8'h80;
                end
                5'd1:  step_byte = "H";
                5'd2:  step_byte = ":";
                5'd3:  step_byte = snap_q[10];
                5'd4:  step_byte = snap_q[9];
                5'd5:  step_byte = snap_q[8];
                5'd6:  step_byte = " ";
                5'd7:  step_byte = "G";
                5'd8:  step_byte = ":";
                5'd9:  step_byte = snap_q[7];
                5'd10: step_byte = snap_q[6];
                5'd11: step_byte = snap_q[5];
                5'd12: begin
                    step_rs   = 1'b0;
                    step_byte = 8'hC0;
                end
                5'd13: step_byte = snap_q[4];
                5'd14: step_byte = snap_q[3];
                5'd15: step_byte = ":";
                5'd16: step_byte = snap_q[2];
                5'd17: step_byte = snap_q[1];
                5'd18: step_byte = " ";
                5'd19: step_byte = "P";
                5'd20: step_byte = ":";
                5'd21: step_byte = snap_q[0];
                default: step_byte = 8'h00;
            endcase
        end
    end

    // Outputs: decoded from state so reset clears lcd_en without waiting for a clock.
    always_comb begin
        lcd_en   = 1'b0;
        lcd_rs   = 1'b0;
        lcd_rw   = 1'b0;
        lcd_data = 8'h00;
        if (state_q != StPwrWait) begin
            lcd_en   = (state_q == StEnHi);
            lcd_rs   = step_rs;
            lcd_data = step_byte;
        end
    end

    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_writer.sv
// Directed bench for lcd_writer with short timing parameters; a negedge monitor logs
// every lcd_en rising edge and frame_done pulse, and scenario tasks check the logs.
module tb_lcd_writer;

    localparam int unsigned TPwr = 20;
    localparam int unsigned TEn  = 2;
    localparam int unsigned TCmd = 4;
    localparam int unsigned TClr = 8;
    localparam int WrLen = 1 + 2 + 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] a0h, a1h, a2h, a0g, a1g, a2g, a0m, a1m, a0s, a1s, a0p;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, frame_done;

    int n_checks;
    int n_fail;
    int cyc;
    int rel_cyc;

    logic [7:0] wr_data[$];
    logic       wr_rs[$];
    int         wr_cyc[$];
    int         fd_cyc[$];
    int         unstable;
    int         fd_wide;
    logic       en_prev, fd_prev, rs_prev;
    logic [7:0] data_prev;

    lcd_writer #(
        .T_PWR(TPwr),
        .T_EN (TEn),
        .T_CMD(TCmd),
        .T_CLR(TClr)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .ascii_0_H     (a0h),
        .ascii_1_H     (a1h),
        .ascii_2_H     (a2h),
        .ascii_0_G     (a0g),
        .ascii_1_G     (a1g),
        .ascii_2_G     (a2g),
        .ascii_0_min   (a0m),
        .ascii_1_min   (a1m),
        .ascii_0_sec   (a0s),
        .ascii_1_sec   (a1s),
        .ascii_0_period(a0p),
        .lcd_data      (lcd_data),
        .lcd_rs        (lcd_rs),
        .lcd_rw        (lcd_rw),
        .lcd_en        (lcd_en),
        .frame_done    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            en_prev <= 1'b0;
            fd_prev <= 1'b0;
        end else begin
            if (lcd_en && !en_prev) begin
                wr_data.push_back(lcd_data);
                wr_rs.push_back(lcd_rs);
                wr_cyc.push_back(cyc);
                if (lcd_data !== data_prev || lcd_rs !== rs_prev) unstable <= unstable + 1;
            end
            if (lcd_en && en_prev && (lcd_data !== data_prev || lcd_rs !== rs_prev))
                unstable <= unstable + 1;
            if (frame_done) begin
                if (fd_prev) fd_wide <= fd_wide + 1;
                else fd_cyc.push_back(cyc);
            end
            en_prev <= lcd_en;
            fd_prev <= frame_done;
        end
        data_prev <= lcd_data;
        rs_prev   <= lcd_rs;
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (lcd_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_en: got %b want 0", lcd_en);
        end
        n_checks++;
        if (lcd_rs !== 1'b0 || lcd_rw !== 1'b0) begin
            n_fail++; $display("FAIL reset_rs_rw: got %b%b want 00", lcd_rs, lcd_rw);
        end
        n_checks++;
        if (lcd_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_data: got %h want 00", lcd_data);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done);
        end
        @(negedge clk);
        rel_cyc = cyc;
        rst_n   = 1'b1;
    endtask

    // Checks the power-up gap and init sequence starting at write index base.
    task automatic test_init(input int base, input string tag);
        logic [7:0] exp_cmd[4];
        exp_cmd[0] = 8'h38; exp_cmd[1] = 8'h0C; exp_cmd[2] = 8'h06; exp_cmd[3] = 8'h01;
        for (int i = 0; i < 400 && wr_data.size() < base + 5; i++) @(negedge clk);
        n_checks++;
        if (wr_data.size() < base + 5) begin
            n_fail++;
            $display("FAIL %s_timeout: got %0d writes want %0d", tag, wr_data.size(), base + 5);
            return;
        end
        // Power-up wait of 20 cycles, then 1 setup cycle before lcd_en rises.
        n_checks++;
        if (wr_cyc[base] - rel_cyc != 21) begin
            n_fail++;
            $display("FAIL %s_first_en: got %0d want 21", tag, wr_cyc[base] - rel_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_data[base+i] !== exp_cmd[i] || wr_rs[base+i] !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_cmd%0d: got rs=%b %h want rs=0 %h", tag, i,
                         wr_rs[base+i], wr_data[base+i], exp_cmd[i]);
            end
        end
        n_checks++;
        if (wr_cyc[base+1] - wr_cyc[base] != WrLen) begin
            n_fail++;
            $display("FAIL %s_cmd_spacing: got %0d want %0d", tag,
                     wr_cyc[base+1] - wr_cyc[base], WrLen);
        end
        // Clear waits 8 cycles: 1 + 2 + 8 between en rises.
        n_checks++;
        if (wr_cyc[base+4] - wr_cyc[base+3] != 11) begin
            n_fail++;
            $display("FAIL %s_clr_gap: got %0d want 11", tag, wr_cyc[base+4] - wr_cyc[base+3]);
        end
        n_checks++;
        if (wr_data[base+4] !== 8'h80 || wr_rs[base+4] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_first_frame_cmd: got rs=%b %h want rs=0 80", tag,
                     wr_rs[base+4], wr_data[base+4]);
        end
    endtask

    task automatic test_frame();
        string      l1, l2;
        logic [7:0] exp_b[22];
        logic       exp_r[22];
        int         bad;
        l1 = "H:105 G:098";
        l2 = "09:45 P:3";
        exp_b[0] = 8'h80; exp_r[0] = 1'b0;
        for (int i = 0; i < 11; i++) begin exp_b[1+i] = l1[i]; exp_r[1+i] = 1'b1; end
        exp_b[12] = 8'hC0; exp_r[12] = 1'b0;
        for (int i = 0; i < 9; i++) begin exp_b[13+i] = l2[i]; exp_r[13+i] = 1'b1; end
        for (int i = 0; i < 400 && wr_data.size() < 26; i++) @(negedge clk);
        n_checks++;
        if (wr_data.size() < 26) begin
            n_fail++; $display("FAIL frame_timeout: got %0d writes want 26", wr_data.size());
            return;
        end
        for (int i = 0; i < 22; i++) begin
            n_checks++;
            if (wr_data[4+i] !== exp_b[i] || wr_rs[4+i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL frame_byte%0d: got rs=%b %h want rs=%b %h", i,
                         wr_rs[4+i], wr_data[4+i], exp_r[i], exp_b[i]);
            end
        end
        bad = 0;
        for (int i = 5; i < 26; i++) if (wr_cyc[i] - wr_cyc[i-1] != WrLen) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL frame_spacing: got %0d bad gaps want 0", bad);
        end
    endtask

    task automatic test_snapshot();
        // Frame 2 occupies writes 26..47; its home-ones digit is write 31.
        for (int i = 0; i < 400 && wr_data.size() < 28; i++) @(negedge clk);
        a0h = "7";
        for (int i = 0; i < 400 && wr_data.size() < 54; i++) @(negedge clk);
        n_checks++;
        if (wr_data.size() < 54) begin
            n_fail++; $display("FAIL snap_timeout: got %0d writes want 54", wr_data.size());
            return;
        end
        n_checks++;
        if (wr_data[31] !== "5") begin
            n_fail++; $display("FAIL snap_current_frame: got %h want 35", wr_data[31]);
        end
        n_checks++;
        if (wr_data[53] !== "7") begin
            n_fail++; $display("FAIL snap_next_frame: got %h want 37", wr_data[53]);
        end
    endtask

    task automatic test_frame_period();
        for (int i = 0; i < 400 && fd_cyc.size() < 2; i++) @(negedge clk);
        n_checks++;
        if (fd_cyc.size() < 2) begin
            n_fail++; $display("FAIL fd_timeout: got %0d pulses want 2", fd_cyc.size());
            return;
        end
        n_checks++;
        if (fd_cyc[1] - fd_cyc[0] != 154) begin
            n_fail++; $display("FAIL fd_period: got %0d want 154", fd_cyc[1] - fd_cyc[0]);
        end
        n_checks++;
        if (fd_wide != 0) begin
            n_fail++; $display("FAIL fd_width: got %0d wide pulses want 0", fd_wide);
        end
        // Pulse coincides with the 0x80 setup cycle, one cycle before its en rise.
        n_checks++;
        if (fd_cyc[0] != wr_cyc[26] - 1) begin
            n_fail++; $display("FAIL fd_align: got %0d want %0d", fd_cyc[0], wr_cyc[26] - 1);
        end
        n_checks++;
        if (unstable != 0) begin
            n_fail++; $display("FAIL data_stable: got %0d changes want 0", unstable);
        end
    endtask

    task automatic test_reset_midwrite();
        int base;
        int seen;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (lcd_en) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL midrst_no_en: got 0 want 1");
            return;
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (lcd_en !== 1'b0) begin
            n_fail++; $display("FAIL midrst_en_drop: got %b want 0", lcd_en);
        end
        n_checks++;
        if ({lcd_rs, lcd_rw, frame_done, lcd_data} !== 11'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got rs=%b rw=%b fd=%b data=%h want all 0",
                     lcd_rs, lcd_rw, frame_done, lcd_data);
        end
        repeat (3) @(negedge clk);
        base    = wr_data.size();
        rel_cyc = cyc;
        rst_n   = 1'b1;
        test_init(base, "reinit");
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; rel_cyc = 0;
        unstable = 0; fd_wide = 0;
        rst_n = 1'b0;
        a2h = "1"; a1h = "0"; a0h = "5";
        a2g = "0"; a1g = "9"; a0g = "8";
        a1m = "0"; a0m = "9"; a1s = "4"; a0s = "5";
        a0p = "3";
        test_reset();
        test_init(0, "init");
        test_frame();
        test_snapshot();
        test_frame_period();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
